// File: rtl/booth_seq_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   state_t : FSM state encoding. The fourth code (2'd3) is never entered
//             and falls back to ST_IDLE if it ever shows up.
//   ADD_OP / SUB_OP : select values for the add_sub input of the adder.
package booth_seq_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

endpackage

// File: rtl/simplified_signed_adder.sv
// Shared two's-complement add/subtract datapath.
//   a, b      : WIDTH-bit operands
//   add_sub   : 0 = a + b, 1 = a - b (b inverted plus carry-in of one)
//   sum       : WIDTH-bit result (wraps modulo 2^WIDTH)
//   carry_out : carry out of the MSB
module simplified_signed_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = b ^ {WIDTH{add_sub}};
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_sub};

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth signed multiplier, one Booth step per clock.
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   start        : request; only looked at in IDLE or DONE
//   multiplicand : signed M, captured when start is accepted
//   multiplier   : signed Q, captured when start is accepted
//   busy         : high while the Booth steps run (WIDTH cycles)
//   done         : one-cycle pulse, product valid
//   product      : signed 2*WIDTH result, held until the next run completes
//   fsm_state    : current FSM state, for observation
//
// Handshake: start is accepted at a rising edge when the FSM is in IDLE or
// DONE; the operands are copied on that edge. busy is high for the following
// WIDTH cycles, then done is high for exactly one cycle. Holding start in the
// DONE cycle launches the next operation immediately. start while busy is
// ignored.
module booth_seq_multiplier
    import booth_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output state_t             fsm_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic             load;
    logic             step;
    logic             last_step;

    // A carries one guard bit so that subtracting M = -2^(WIDTH-1) cannot
    // overflow the accumulator.
    logic [WIDTH:0]   a_reg;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_1;
    logic [CNT_W-1:0] cnt;

    logic             add_sub;
    logic [WIDTH:0]   adder_sum;
    logic             unused_carry;
    logic [WIDTH:0]   a_next;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_RUN;
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) next_state = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    next_state = ST_RUN;
                    load       = 1'b1;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign last_step = step && (cnt == CNT_W'(1));
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

    // ---------------- Datapath ----------------
    // Booth pair {Q[0], q_1}: 10 subtracts M, 01 adds M, 00/11 keep A.
    assign add_sub = (q_reg[0] && !q_1) ? SUB_OP : ADD_OP;

    simplified_signed_adder #(
        .WIDTH (WIDTH + 1)
    ) u_adder (
        .a         (a_reg),
        .b         (m_reg),
        .add_sub   (add_sub),
        .sum       (adder_sum),
        .carry_out (unused_carry)
    );

    assign a_next = (q_reg[0] ^ q_1) ? adder_sum : a_reg;

    // Arithmetic shift right of {A', Q, q_1}; A'[WIDTH] is replicated.
    assign a_sh = {a_next[WIDTH], a_next[WIDTH:1]};
    assign q_sh = {a_next[0], q_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (load) begin
            a_reg <= '0;
            m_reg <= {multiplicand[WIDTH-1], multiplicand};
            q_reg <= multiplier;
            q_1   <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
        end else if (step) begin
            a_reg <= a_sh;
            q_reg <= q_sh;
            q_1   <= q_reg[0];
            cnt   <= cnt - CNT_W'(1);
            if (last_step) product <= {a_sh[WIDTH-1:0], q_sh};
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;
    import booth_seq_multiplier_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic        start = 1'b0;
    logic [7:0]  mc = '0;
    logic [7:0]  mp = '0;
    logic        busy, done;
    logic [15:0] product;
    state_t      fsm_state;

    // WIDTH = 4 instance for the exhaustive sweep
    logic        start4 = 1'b0;
    logic [3:0]  mc4 = '0;
    logic [3:0]  mp4 = '0;
    logic        busy4, done4;
    logic [7:0]  product4;
    state_t      fsm_state4;

    booth_seq_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .multiplicand(mc), .multiplier(mp),
        .busy(busy), .done(done), .product(product), .fsm_state(fsm_state)
    );

    booth_seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4),
        .multiplicand(mc4), .multiplier(mp4),
        .busy(busy4), .done(done4), .product(product4), .fsm_state(fsm_state4)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer multiply, truncated to the product width.
    function automatic logic [15:0] ref_mul8(input logic [7:0] m, input logic [7:0] q);
        int r;
        r = int'($signed(m)) * int'($signed(q));
        return r[15:0];
    endfunction

    function automatic logic [7:0] ref_mul4(input logic [3:0] m, input logic [3:0] q);
        int r;
        r = int'($signed(m)) * int'($signed(q));
        return r[7:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Called at the falling edge of cycle 1 (first cycle after the accepting
    // edge). Returns the cycle number in which done was seen (-1 on timeout).
    task automatic wait_done(output logic [15:0] p, output int cyc,
                             output int bcnt, output bit ov);
        cyc  = -1;
        bcnt = 0;
        ov   = 1'b0;
        p    = '0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) bcnt++;
            if (busy && done) ov = 1'b1;
            if (done) begin
                cyc = k;
                p   = product;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [7:0] m, input logic [7:0] q,
                         output logic [15:0] p, output int cyc,
                         output int bcnt, output bit ov);
        start = 1'b1;
        mc    = m;
        mp    = q;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mc    = 8'($urandom);
        mp    = 8'($urandom);
        wait_done(p, cyc, bcnt, ov);
        @(negedge clk);
    endtask

    task automatic do_op4(input logic [3:0] m, input logic [3:0] q,
                          output logic [7:0] p, output bit got);
        start4 = 1'b1;
        mc4    = m;
        mp4    = q;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        mc4    = 4'($urandom);
        mp4    = 4'($urandom);
        got    = 1'b0;
        p      = '0;
        for (int k = 1; k <= 20; k++) begin
            if (done4) begin
                got = 1'b1;
                p   = product4;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] p;
        logic [7:0]  p4;
        int          cyc, bcnt;
        bit          ov, got;
        logic [7:0]  rm, rq;

        vecs[0] = '{8'h07, 8'h03, 16'h0015};
        vecs[1] = '{8'hFB, 8'h03, 16'hFFF1};
        vecs[2] = '{8'h80, 8'h80, 16'h4000};
        vecs[3] = '{8'h80, 8'h7F, 16'hC080};
        vecs[4] = '{8'h00, 8'h80, 16'h0000};
        vecs[5] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[6] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[7] = '{8'h80, 8'h01, 16'hFF80};

        // reset state
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].m, vecs[i].q, p, cyc, bcnt, ov);
            check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].exp));
            check($sformatf("vec%0d_done_cycle", i), 32'(cyc), 32'd9);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd8);
            check($sformatf("vec%0d_no_overlap", i), 32'(ov), 32'd0);
        end
        check("idle_after_done", 32'(fsm_state), 32'(ST_IDLE));

        // back-to-back with start held high; operands switched during RUN
        start = 1'b1;
        mc    = 8'd2;
        mp    = 8'd3;
        @(posedge clk);
        @(negedge clk);
        mc = 8'd4;
        mp = 8'd5;
        wait_done(p, cyc, bcnt, ov);
        check("b2b_first_product", 32'(p), 32'd6);
        check("b2b_first_cycle", 32'(cyc), 32'd9);
        @(negedge clk);
        check("b2b_accept_busy", 32'(busy), 32'd1);
        check("b2b_accept_done", 32'(done), 32'd0);
        check("b2b_product_held", 32'(product), 32'd6);
        start = 1'b0;
        wait_done(p, cyc, bcnt, ov);
        check("b2b_second_product", 32'(p), 32'd20);
        check("b2b_second_cycle", 32'(cyc), 32'd9);
        @(negedge clk);

        // reset mid-RUN (cycle 4)
        start = 1'b1;
        mc    = 8'd9;
        mp    = 8'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        got = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) got = 1'b1;
        end
        check("abort_no_done", 32'(got), 32'd0);
        do_op(8'hFF, 8'hFF, p, cyc, bcnt, ov);
        check("after_abort_product", 32'(p), 32'd1);
        check("after_abort_cycle", 32'(cyc), 32'd9);

        // randomized sweep against the integer reference
        for (int n = 0; n < 2000; n++) begin
            rm = 8'($urandom_range(0, 255));
            rq = 8'($urandom_range(0, 255));
            do_op(rm, rq, p, cyc, bcnt, ov);
            check($sformatf("rand_%0h_x_%0h", rm, rq), 32'(p), 32'(ref_mul8(rm, rq)));
            check("rand_done_cycle", 32'(cyc), 32'd9);
        end

        // exhaustive sweep at WIDTH = 4
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op4(4'(i), 4'(j), p4, got);
                check("w4_done_seen", 32'(got), 32'd1);
                check($sformatf("w4_%0d_x_%0d", i, j), 32'(p4), 32'(ref_mul4(4'(i), 4'(j))));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
